// File: rtl/uart_rx_fifo_if.sv
// Receive-buffer bus: the word stream from the UART receiver, the host-side
// valid/ready read port, and the status/control signals of the buffer.
interface uart_rx_fifo_if #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16,
  parameter int CNT_BITS  = 8
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  // Receiver side
  logic [DATA_BITS-1:0] wr_data;
  logic                 wr_strobe;

  // Host read side
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_valid;
  logic                 rd_ready;

  // Control and status
  logic                 flush;
  logic [LVL_W-1:0]     level;
  logic                 full;
  logic                 overrun;
  logic                 overrun_clear;
  logic [CNT_BITS-1:0]  dropped_count;

  // The master is whatever feeds the buffer and consumes its output.
  modport master (
    output wr_data, wr_strobe, rd_ready, flush, overrun_clear,
    input  rd_data, rd_valid, level, full, overrun, dropped_count
  );

  modport slave (
    input  wr_data, wr_strobe, rd_ready, flush, overrun_clear,
    output rd_data, rd_valid, level, full, overrun, dropped_count
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer behind the UART receiver: captures
// strobed words, serves them on valid/ready, and counts words lost to overrun.
module uart_rx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16,
  parameter int CNT_BITS  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  uart_rx_fifo_if.slave     bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int LVL_W = $clog2(DEPTH + 1);

  // Storage and pointers; the extra pointer MSB separates full from empty.
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [LVL_W-1:0]     level_q;
  logic                 overrun_q;
  logic [CNT_BITS-1:0]  dropped_q;

  logic [IDX_W-1:0]     wr_idx;
  logic [IDX_W-1:0]     rd_idx;
  logic                 empty;
  logic                 full;

  logic                 pop;
  logic                 wr_accept;
  logic                 wr_drop;
  logic [PTR_W-1:0]     wr_ptr_nxt;
  logic [PTR_W-1:0]     rd_ptr_nxt;
  logic [PTR_W-1:0]     level_nxt;

  assign wr_idx = wr_ptr[IDX_W-1:0];
  assign rd_idx = rd_ptr[IDX_W-1:0];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_idx == rd_idx) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);

  // Flush overrides both ports: a coincident pop is ignored and a coincident
  // write is silently discarded rather than counted as a drop.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path through
    // the conditionals can leave one unassigned and infer a latch.
    pop        = 1'b0;
    wr_accept  = 1'b0;
    wr_drop    = 1'b0;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;

    if (bus.flush) begin
      rd_ptr_nxt = wr_ptr;
    end else begin
      pop = !empty && bus.rd_ready;
      if (bus.wr_strobe) begin
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        if (!full || pop) wr_accept = 1'b1;
        else              wr_drop   = 1'b1;
      end
      if (wr_accept) wr_ptr_nxt = wr_ptr + PTR_W'(1);
      if (pop)       rd_ptr_nxt = rd_ptr + PTR_W'(1);
    end

    level_nxt = wr_ptr_nxt - rd_ptr_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      level_q <= LVL_W'(level_nxt);
    end
  end

  // NOTE: the storage array deliberately has no reset; the pointers alone
  // define which entries are meaningful, and an un-reset array maps to RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_idx] <= bus.wr_data;
  end

  // Overrun flag and saturating drop counter. A drop in the same cycle as a
  // clear wins, so the event that caused the clear race is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun_q <= 1'b0;
      dropped_q <= '0;
    end else if (wr_drop) begin
      overrun_q <= 1'b1;
      if (bus.overrun_clear)  dropped_q <= CNT_BITS'(1);
      else if (!(&dropped_q)) dropped_q <= dropped_q + CNT_BITS'(1);
    end else if (bus.overrun_clear) begin
      overrun_q <= 1'b0;
      dropped_q <= '0;
    end
  end

  assign bus.rd_data       = mem[rd_idx];
  assign bus.rd_valid      = !empty;
  assign bus.level         = level_q;
  assign bus.full          = full;
  assign bus.overrun       = overrun_q;
  assign bus.dropped_count = dropped_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue-based model.
module tb_uart_rx_fifo;

  localparam int DATA_BITS = 8;
  localparam int DEPTH     = 16;
  localparam int CNT_BITS  = 8;
  localparam int CNT_MAX   = (1 << CNT_BITS) - 1;

  logic clk;
  logic reset_n;

  uart_rx_fifo_if #(.DATA_BITS(DATA_BITS), .DEPTH(DEPTH), .CNT_BITS(CNT_BITS)) bus ();

  uart_rx_fifo #(.DATA_BITS(DATA_BITS), .DEPTH(DEPTH), .CNT_BITS(CNT_BITS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the FIFO contents as a queue plus the overrun state.
  logic [DATA_BITS-1:0] mq[$];
  bit                   m_ovr;
  int                   m_cnt;

  typedef struct {
    logic                 strobe;
    logic [DATA_BITS-1:0] data;
    logic                 ready;
    logic                 flush;
    logic                 clr;
    logic                 exp_valid;
    logic [DATA_BITS-1:0] exp_data;
    int                   exp_level;
    logic                 exp_full;
    logic                 exp_ovr;
    int                   exp_cnt;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " rd_valid"}, 32'(bus.rd_valid), 32'(mq.size() != 0));
    check({tag, " level"}, 32'(bus.level), 32'(mq.size()));
    check({tag, " full"}, 32'(bus.full), 32'(mq.size() == DEPTH));
    check({tag, " overrun"}, 32'(bus.overrun), 32'(m_ovr));
    check({tag, " dropped_count"}, 32'(bus.dropped_count), 32'(m_cnt));
    if (mq.size() != 0) check({tag, " rd_data"}, 32'(bus.rd_data), 32'(mq[0]));
  endtask

  // Applies the rules of one clock edge to the model, from the current inputs.
  task automatic model_update();
    bit pop;
    bit drop;
    pop  = (mq.size() != 0) && bus.rd_ready && !bus.flush;
    drop = 1'b0;
    if (bus.flush) begin
      mq.delete();
    end else begin
      if (bus.wr_strobe && mq.size() == DEPTH && !pop) drop = 1'b1;
      if (pop) void'(mq.pop_front());
      if (bus.wr_strobe && !drop) mq.push_back(bus.wr_data);
    end
    if (drop) begin
      m_ovr = 1'b1;
      if (bus.overrun_clear) m_cnt = 1;
      else if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end else if (bus.overrun_clear) begin
      m_ovr = 1'b0;
      m_cnt = 0;
    end
  endtask

  task automatic drive(input logic strobe, input logic [DATA_BITS-1:0] data,
                       input logic ready, input logic flush, input logic clr);
    bus.wr_strobe     = strobe;
    bus.wr_data       = data;
    bus.rd_ready      = ready;
    bus.flush         = flush;
    bus.overrun_clear = clr;
  endtask

  // One clock: update the model from the applied inputs, then sample 1 ns after the edge.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovr = 1'b0;
    m_cnt = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1, 1'b0, 1'b0, 0};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 0};
    vecs[2] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 1, 1'b0, 1'b0, 0};
    vecs[3] = '{1'b1, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b1, 8'h7E, 1, 1'b0, 1'b0, 0};
    vecs[4] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 8'h7E, 2, 1'b0, 1'b0, 0};
    vecs[5] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 0};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 0};
    vecs[7] = '{1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 1'b1, 8'h99, 1, 1'b0, 1'b0, 0};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0, 0};

    reset_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #12;
    check_model("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_model("after reset release");

    // Directed vectors: single-word latency, write+pop at level 1, flush.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].strobe, vecs[i].data, vecs[i].ready, vecs[i].flush, vecs[i].clr);
      step();
      check($sformatf("vec%0d rd_valid", i), 32'(bus.rd_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d level", i), 32'(bus.level), 32'(vecs[i].exp_level));
      check($sformatf("vec%0d full", i), 32'(bus.full), 32'(vecs[i].exp_full));
      check($sformatf("vec%0d overrun", i), 32'(bus.overrun), 32'(vecs[i].exp_ovr));
      check($sformatf("vec%0d dropped_count", i), 32'(bus.dropped_count), 32'(vecs[i].exp_cnt));
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d rd_data", i), 32'(bus.rd_data), 32'(vecs[i].exp_data));
      check_model($sformatf("vec%0d model", i));
    end

    // Fill to full with 0x00..0x0F.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, DATA_BITS'(i), 1'b0, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("fill full", 32'(bus.full), 32'd1);
    check("fill level", 32'(bus.level), 32'd16);
    check("fill head", 32'(bus.rd_data), 32'h00);

    // Three strobes into a full FIFO are dropped.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, DATA_BITS'(8'h10 + i), 1'b0, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("drop overrun", 32'(bus.overrun), 32'd1);
    check("drop count", 32'(bus.dropped_count), 32'd3);
    check("drop level", 32'(bus.level), 32'd16);
    check("drop head", 32'(bus.rd_data), 32'h00);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step();
    check("clear overrun", 32'(bus.overrun), 32'd0);
    check("clear count", 32'(bus.dropped_count), 32'd0);

    // Full with simultaneous write and pop: accepted, no overrun.
    drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    step();
    check("full wr+pop level", 32'(bus.level), 32'd16);
    check("full wr+pop overrun", 32'(bus.overrun), 32'd0);
    check("full wr+pop head", 32'(bus.rd_data), 32'h01);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain valid %0d", i), 32'(bus.rd_valid), 32'd1);
      check($sformatf("drain data %0d", i), 32'(bus.rd_data), (i < DEPTH - 1) ? 32'(i + 1) : 32'h55);
      step();
    end
    check("drain empty", 32'(bus.rd_valid), 32'd0);
    check("drain level", 32'(bus.level), 32'd0);

    // Pointer wrap: hold level at 2 while streaming 40 write/pop pairs.
    drive(1'b1, 8'hC0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, DATA_BITS'(8'h20 + i), 1'b1, 1'b0, 1'b0);
      step();
      check_model($sformatf("wrap %0d", i));
      if (bus.level > 3) check($sformatf("wrap level bound %0d", i), 32'(bus.level), 32'd3);
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step();
    step();
    check("wrap drained", 32'(bus.rd_valid), 32'd0);

    // Saturation of the drop counter, then drop racing a clear.
    for (int i = 0; i < DEPTH + CNT_MAX + 5; i++) begin
      drive(1'b1, DATA_BITS'($urandom), 1'b0, 1'b0, 1'b0);
      step();
    end
    check("sat count", 32'(bus.dropped_count), 32'(CNT_MAX));
    check("sat overrun", 32'(bus.overrun), 32'd1);
    drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    step();
    check("drop wins overrun", 32'(bus.overrun), 32'd1);
    check("drop wins count", 32'(bus.dropped_count), 32'd1);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step();
    check("flush keeps overrun", 32'(bus.overrun), 32'd1);
    check("flush empties", 32'(bus.level), 32'd0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step();
    check_model("post clear");

    // Level 5, then flush with a coincident strobe.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, DATA_BITS'(8'h40 + i), 1'b0, 1'b0, 1'b0);
      step();
    end
    check("pre-flush level", 32'(bus.level), 32'd5);
    drive(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    step();
    check("flush level", 32'(bus.level), 32'd0);
    check("flush rd_valid", 32'(bus.rd_valid), 32'd0);
    check("flush overrun", 32'(bus.overrun), 32'd0);

    // Asynchronous reset in the middle of a write burst.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, DATA_BITS'(8'h60 + i), 1'b0, 1'b0, 1'b0);
      step();
    end
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("async reset rd_valid", 32'(bus.rd_valid), 32'd0);
    check("async reset level", 32'(bus.level), 32'd0);
    check("async reset full", 32'(bus.full), 32'd0);
    check("async reset overrun", 32'(bus.overrun), 32'd0);
    check("async reset count", 32'(bus.dropped_count), 32'd0);
    @(posedge clk);
    #1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    check_model("after mid reset");

    // Randomized traffic against the model, in phases of varying pressure.
    for (int phase = 0; phase < 4; phase++) begin
      for (int i = 0; i < 600; i++) begin
        drive(($urandom_range(99) < 55),
              DATA_BITS'($urandom),
              ($urandom_range(99) < (phase * 25 + 10)),
              ($urandom_range(79) == 0),
              ($urandom_range(39) == 0));
        step();
        check_model($sformatf("rand p%0d c%0d", phase, i));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
